// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: word/half/byte loads and stores onto a word-wide SRAM
// without byte enables; sub-word stores use read-modify-write. Optional macro: DM_ALIGN_CHECK_EN.
module dm_access_ctrl #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_dmwr,
   input  logic [2:0]            req_dmre,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   localparam logic [1:0] WR_SW = 2'd1, WR_SH = 2'd2, WR_SB = 2'd3;
   localparam logic [2:0] RE_LW = 3'd1, RE_LH = 3'd2, RE_LHU = 3'd3, RE_LB = 3'd4, RE_LBU = 3'd5;

   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

   state_t      state;
   logic        rmw;
   logic        ld;
   logic [1:0]  dmwr_q;
   logic [2:0]  dmre_q;
   logic [1:0]  lane_q;
   logic [31:0] data_q;

   logic        illegal;
   logic        misalign;
   logic        unused_addr;

   assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
   assign illegal     = ((req_dmwr != 2'd0) && (req_dmre != 3'd0)) || (req_dmre > RE_LBU);

`ifdef DM_ALIGN_CHECK_EN
   assign misalign = (((req_dmwr == WR_SW) || (req_dmre == RE_LW)) && (req_addr[1:0] != 2'b00)) ||
                     (((req_dmwr == WR_SH) || (req_dmre == RE_LH) || (req_dmre == RE_LHU)) && req_addr[0]);
`else
   // Low address bits are simply not used by word/halfword lane selection.
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         rmw        <= 1'b0;
         ld         <= 1'b0;
         dmwr_q     <= 2'd0;
         dmre_q     <= 3'd0;
         lane_q     <= 2'd0;
         data_q     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  dmwr_q    <= req_dmwr;
                  dmre_q    <= req_dmre;
                  lane_q    <= req_addr[1:0];
                  data_q    <= req_wdata;
                  mem_addr  <= req_addr[ADDR_WIDTH+1:2];
                  if (illegal || misalign) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_dmre != 3'd0) begin
                     state  <= READ;
                     mem_en <= 1'b1;
                     ld     <= 1'b1;
                  end else if (req_dmwr == WR_SW) begin
                     state  <= WRITE;
                     mem_en <= 1'b1;
                     mem_we <= 1'b1;
                  end else if (req_dmwr != 2'd0) begin
                     state  <= READ;
                     mem_en <= 1'b1;
                     rmw    <= 1'b1;
                  end else begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                  end
               end
            end
            READ: begin
               if (rmw) begin
                  state  <= MERGE;
                  mem_we <= 1'b1;
               end else begin
                  state      <= RESP;
                  mem_en     <= 1'b0;
                  resp_valid <= 1'b1;
               end
            end
            MERGE, WRITE: begin
               state      <= RESP;
               mem_en     <= 1'b0;
               mem_we     <= 1'b0;
               resp_valid <= 1'b1;
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               rmw        <= 1'b0;
               ld         <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
            end
         endcase
      end
   end

   // SRAM read data is live in the cycle after READ, i.e. during MERGE or RESP.
   logic [31:0] merged;
   logic [15:0] half;
   logic [7:0]  byte_sel;

   always_comb begin
      merged = mem_rdata;
      if (dmwr_q == WR_SB) begin
         case (lane_q)
            2'd0:    merged[7:0]   = data_q[7:0];
            2'd1:    merged[15:8]  = data_q[7:0];
            2'd2:    merged[23:16] = data_q[7:0];
            default: merged[31:24] = data_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merged[31:16] = data_q[15:0];
      end else begin
         merged[15:0] = data_q[15:0];
      end
   end

   always_comb begin
      mem_wdata = 32'd0;
      if (state == MERGE)      mem_wdata = merged;
      else if (state == WRITE) mem_wdata = data_q;
   end

   always_comb begin
      half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lane_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
   end

   always_comb begin
      resp_rdata = 32'd0;
      if (resp_valid && ld) begin
         case (dmre_q)
            RE_LW:   resp_rdata = mem_rdata;
            RE_LH:   resp_rdata = {{16{half[15]}}, half};
            RE_LHU:  resp_rdata = {16'd0, half};
            RE_LB:   resp_rdata = {{24{byte_sel[7]}}, byte_sel};
            RE_LBU:  resp_rdata = {24'd0, byte_sel};
            default: resp_rdata = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: driver pushes expected responses, a negedge
// monitor pops and checks data, error, latency and SRAM access count.
module tb_dm_access_ctrl;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_dmwr;
   logic [2:0]    req_dmre;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   dm_access_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dmwr(req_dmwr), .req_dmre(req_dmre), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port SRAM model
   logic [31:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nmem;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int memcnt = 0;
   int memcnt_acc = 0;
   logic prev_rv = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rstn && req_valid && req_ready) begin
         acc_cyc    <= cyc;
         memcnt_acc <= memcnt;
      end
   end

   always @(negedge clk) begin
      if (rstn && mem_en) memcnt = memcnt + 1;
      if (rstn && resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            chk("latency", cyc - acc_cyc, e.lat);
            chk("mem_accesses", memcnt - memcnt_acc, e.nmem);
         end
      end
      if (rstn && prev_rv && !resp_valid) begin
         chk("post_resp_rdata", resp_rdata, 32'd0);
         chk("post_resp_err", {31'd0, resp_err}, 32'd0);
      end
      prev_rv = resp_valid;
   end

   task automatic issue(input logic [1:0] wr, input logic [2:0] re, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input int el, input int en);
      exp_t e;
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
      e.rdata = er; e.err = ee; e.lat = el; e.nmem = en;
      q.push_back(e);
      req_dmwr = wr; req_dmre = re; req_addr = a; req_wdata = d; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_dmwr = 2'd0; req_dmre = 3'd0;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("resp_timeout", 32'd0, 32'd1);
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = 32'd0;
      rstn = 1'b0; req_valid = 1'b0; req_dmwr = 2'd0; req_dmre = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // SW then LW
      issue(2'd1, 3'd0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1);
      chk("sram_w4_sw", mem[4], 32'hDEADBEEF);
      issue(2'd0, 3'd1, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1);

      // SB / SH read-modify-write
      issue(2'd1, 3'd0, 32'h10, 32'h11223344, 32'd0, 1'b0, 2, 1);
      issue(2'd3, 3'd0, 32'h13, 32'hFFFFFFAA, 32'd0, 1'b0, 3, 2);
      chk("sram_w4_sb", mem[4], 32'hAA223344);
      issue(2'd2, 3'd0, 32'h12, 32'hFFFF5566, 32'd0, 1'b0, 3, 2);
      chk("sram_w4_sh", mem[4], 32'h55663344);
      issue(2'd0, 3'd4, 32'h11, 32'd0, 32'h00000033, 1'b0, 2, 1);

      // Sign/zero extension on 0x80FF7F01
      issue(2'd1, 3'd0, 32'h20, 32'h80FF7F01, 32'd0, 1'b0, 2, 1);
      issue(2'd0, 3'd4, 32'h23, 32'd0, 32'hFFFFFF80, 1'b0, 2, 1);
      issue(2'd0, 3'd5, 32'h23, 32'd0, 32'h00000080, 1'b0, 2, 1);
      issue(2'd0, 3'd2, 32'h22, 32'd0, 32'hFFFF80FF, 1'b0, 2, 1);
      issue(2'd0, 3'd3, 32'h20, 32'd0, 32'h00007F01, 1'b0, 2, 1);

      // Misaligned LW
`ifdef DM_ALIGN_CHECK_EN
      issue(2'd0, 3'd1, 32'h21, 32'd0, 32'd0, 1'b1, 1, 0);
`else
      issue(2'd0, 3'd1, 32'h21, 32'd0, 32'h80FF7F01, 1'b0, 2, 1);
`endif

      // Illegal and NOP requests
      issue(2'd1, 3'd1, 32'h20, 32'h12345678, 32'd0, 1'b1, 1, 0);
      chk("sram_w8_illegal", mem[8], 32'h80FF7F01);
      issue(2'd0, 3'd6, 32'h20, 32'd0, 32'd0, 1'b1, 1, 0);
      issue(2'd0, 3'd0, 32'h20, 32'd0, 32'd0, 1'b0, 1, 0);

      // Address wraps modulo SRAM size
      issue(2'd1, 3'd0, 32'h1010, 32'h0BADF00D, 32'd0, 1'b0, 2, 1);
      issue(2'd0, 3'd1, 32'h10, 32'd0, 32'h0BADF00D, 1'b0, 2, 1);

      // Reset during MERGE of an SH
      issue(2'd1, 3'd0, 32'h30, 32'hCAFEF00D, 32'd0, 1'b0, 2, 1);
      req_dmwr = 2'd2; req_dmre = 3'd0; req_addr = 32'h30; req_wdata = 32'h00001234;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0; req_dmwr = 2'd0;
      @(posedge clk);
      #1;
      chk("merge_state_we", {31'd0, mem_we}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("mrst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("mrst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("mrst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("mrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("mrst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      chk("sram_w12_unchanged", mem[12], 32'hCAFEF00D);
      rstn = 1'b1;
      @(negedge clk);
      issue(2'd0, 3'd1, 32'h30, 32'd0, 32'hCAFEF00D, 1'b0, 2, 1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Data-memory access controller for the SCPU. It sits between the datapath's DMWr/DMRe/ALU-address outputs and a word-wide, single-port synchronous SRAM that has no byte enables. It performs word, halfword and byte loads with sign or zero extension, and word, halfword and byte stores. Sub-word stores use a multi-cycle read-modify-write sequence. Requests use a valid/ready handshake, so the core stalls while an access is in flight.

## Interface
- `ADDR_WIDTH`, default 10: SRAM word-address width (4·2^ADDR_WIDTH bytes).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept; high only in IDLE.
- `req_dmwr` input 2: store opcode. 0=NOP, 1=SW, 2=SH, 3=SB.
- `req_dmre` input 3: load opcode. 0=NOP, 1=LW, 2=LH, 3=LHU, 4=LB, 5=LBU; 6/7 illegal.
- `req_addr` input 32: byte address (ALU result).
- `req_wdata` input 32: store data (rt); SH uses [15:0], SB uses [7:0].
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for non-loads.
- `resp_err` output 1: request was illegal or misaligned; qualified by resp_valid.
- `mem_en` output 1: SRAM access enable.
- `mem_we` output 1: SRAM write enable (valid when mem_en=1).
- `mem_addr` output ADDR_WIDTH: word address = `req_addr[ADDR_WIDTH+1:2]`.
- `mem_wdata` output 32: SRAM write data.
- `mem_rdata` input 32: SRAM read data, valid the cycle after a read-enable cycle.

## Operation
- **Handshake.** A request is accepted when `req_valid && req_ready`. Address, data and opcodes are captured at acceptance. Inputs are ignored while busy.
- **States.** IDLE, READ, MERGE, WRITE, RESP.
- **Transitions out of IDLE on accept:**
  - Load: go to READ.
  - SW: go to WRITE.
  - SH or SB: go to READ with the RMW flag set.
  - Both opcodes zero (NOP): go to RESP with no memory access.
  - Illegal request (both opcodes nonzero, or req_dmre 6/7): go to RESP with `resp_err`=1 and no memory access.
- **READ:** `mem_en`=1, `mem_we`=0. Next state is MERGE if RMW, else RESP.
- **MERGE:** `mem_en`=1, `mem_we`=1. `mem_wdata` = `mem_rdata` with the addressed lane replaced:
  - SB replaces byte lane `addr[1:0]`.
  - SH replaces halfword lane `addr[1]`.
  - Next state is RESP.
- **WRITE:** `mem_en`=1, `mem_we`=1, `mem_wdata`=`req_wdata`. Next state is RESP.
- **RESP:** `resp_valid`=1. Next state is IDLE.
- **Byte lanes.** Little-endian: byte 0 = bits [7:0], halfword 0 = bits [15:0].
- **Load extraction** (uses `mem_rdata` captured at the end of READ, registered into `resp_rdata`):
  - LW: the full word.
  - LH/LB: sign-extend the selected lane.
  - LHU/LBU: zero-extend the selected lane.
- **Memory strobes.** `mem_en` and `mem_we` are 0 in IDLE and RESP.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Reset mid-operation:** reset asserted during READ, MERGE or WRITE aborts the access immediately. An RMW may leave the SRAM unmodified; it never leaves a partial write. No response is generated.
- **Latency** (accept = cycle 0):
  - Loads: `resp_valid` in cycle 2.
  - SW: `resp_valid` in cycle 2.
  - SH/SB: `resp_valid` in cycle 3.
  - NOP or error: `resp_valid` in cycle 1.
- **Back-to-back:** `req_ready` returns high the cycle after RESP. Minimum spacing between accepts is 3 cycles (load/SW) or 4 cycles (SH/SB).
- **Output validity:** `resp_rdata` and `resp_err` are valid only while `resp_valid`=1 and return to 0 afterwards.
- **Address range:** `req_addr` bits above `ADDR_WIDTH+1` are ignored, so addresses wrap modulo the SRAM size.

## Configuration
- Macro `DM_ALIGN_CHECK_EN`.
- **Defined:**
  - Misaligned requests are rejected: SW/LW with `addr[1:0]`≠0, or SH/LH/LHU with `addr[0]`≠0.
  - A rejected request goes IDLE→RESP with `resp_err`=1 and makes no memory access.
- **Undefined:**
  - The low address bits are masked instead: word accesses ignore `addr[1:0]`, halfword accesses ignore `addr[0]`.
  - `resp_err` is asserted only for illegal opcodes.

## Test plan
- **SW then LW:** SW addr 0x10, data 0xDEADBEEF → write to word 4 in cycle 1. Then LW 0x10 → `resp_rdata`=0xDEADBEEF in cycle 2.
- **SB RMW:** word 4 = 0x11223344, SB addr 0x13, data 0xAA → READ then MERGE writes 0xAA223344; `resp_valid` in cycle 3.
- **Loads on word 0x80FF7F01 at 0x20:**
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF.
  - LHU 0x20 → 0x00007F01.
- **Misaligned LW 0x21:**
  - With `DM_ALIGN_CHECK_EN`: `resp_err`=1 in cycle 1, `mem_en` never asserted.
  - Without: reads word 8, no error.
- **Illegal request:** `req_dmwr`=1 and `req_dmre`=1 together → `resp_err`=1, no memory access. A NOP request → `resp_valid` in cycle 1 with `resp_rdata`=0.
- **Reset during MERGE of an SH** → all outputs at reset values next cycle, SRAM word unchanged, `req_ready`=1.
